// File: rtl/pla_loop_pkg.sv
// Shared XGMII constants, column type and FSM states for the loop/packing selector.
package pla_loop_pkg;

    localparam logic [7:0]  XGMII_START     = 8'hFB;
    localparam logic [7:0]  XGMII_TERM      = 8'hFD;
    localparam logic [31:0] XGMII_IDLE_WORD = 32'h07070707;
    localparam logic [3:0]  XGMII_IDLE_TXC  = 4'hf;
    // Terminate in lane 0 followed by idles, used to close a frame that never ended
    localparam logic [31:0] XGMII_TERM_WORD = 32'h070707FD;

    typedef struct packed {
        logic [3:0]  txc;
        logic [31:0] data;
    } xcol_t;

    localparam xcol_t XGMII_IDLE_COL = '{txc: XGMII_IDLE_TXC, data: XGMII_IDLE_WORD};

    typedef enum logic [2:0] {
        ST_PLA   = 3'd0,
        ST_BYP   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_GAP   = 3'd3,
        ST_ALIGN = 3'd4
    } state_t;

endpackage

// File: rtl/pla_xgmii_frame_trk.sv
// Per-source XGMII frame tracker: SOF/EOF detection and in-frame flag.
// o_inframe_nxt is the flag after the current column, o_clean says the
// current column starts outside a frame (idle or SOF column).
module pla_xgmii_frame_trk
    import pla_loop_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    input  xcol_t i_col,
    input  logic  i_clr,
    output logic  o_inframe_nxt,
    output logic  o_clean
);

    logic r_inframe;
    logic w_sof;
    logic w_eof;

    assign w_sof = i_col.txc[0] && (i_col.data[7:0] == XGMII_START);

    // Terminate may sit in any lane
    always_comb begin
        w_eof = 1'b0;
        for (int i = 0; i < 4; i++)
            if (i_col.txc[i] && (i_col.data[8*i +: 8] == XGMII_TERM)) w_eof = 1'b1;
    end

    // SOF restarts a frame even when already in one; stray EOF leaves the flag at 0
    assign o_inframe_nxt = i_clr ? 1'b0 : (w_sof ? 1'b1 : (w_eof ? 1'b0 : r_inframe));
    assign o_clean       = !r_inframe;

    // In-frame flag register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_inframe <= 1'b0;
        else       r_inframe <= o_inframe_nxt;
    end

endmodule

// File: rtl/pla_1588_loop_sel_ctrl.sv
// Frame-aware selector between the GMII loop stream and the PLA packing stream.
// Switches only between frames, inserts GAP_CYCLES idle columns, and re-aligns
// to a clean column of the new source. Optional drain watchdog under
// PLA_LOOP_SEL_TIMEOUT_EN (adds O_abort_cnt).
module pla_1588_loop_sel_ctrl
    import pla_loop_pkg::*;
#(
    parameter int GAP_CYCLES     = 3,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic             I_sys_312m_clk,
    input  logic             I_fpga_reset,
    input  logic             I_bypass_en,
    input  logic [3:0]       I_gmii_txc,
    input  logic [31:0]      I_gmii_data,
    input  logic [3:0]       I_pla_packing_txc,
    input  logic [31:0]      I_pla_packing_data,
    output logic [3:0]       O_gmii_txc,
    output logic [31:0]      O_gmii_data,
    output logic             O_bypass_active,
    output logic             O_switch_busy,
    output logic [CNT_W-1:0] O_switch_cnt,
    output logic [CNT_W-1:0] O_drop_cnt
`ifdef PLA_LOOP_SEL_TIMEOUT_EN
    ,
    output logic [CNT_W-1:0] O_abort_cnt
`endif
);

`ifdef PLA_LOOP_SEL_TIMEOUT_EN
    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
`else
    localparam int CNT_MAX = GAP_CYCLES;
`endif
    localparam int TC_W = $clog2(CNT_MAX + 1);

    logic            r_req_meta, r_req;
    xcol_t           r_pla, r_gmii, r_out;
    state_t          r_state, w_state_nxt;
    logic            r_src, w_src_nxt;      // 0 = PLA, 1 = GMII loop
    logic [TC_W-1:0] r_tcnt, w_tcnt_nxt;
    logic [CNT_W-1:0] r_sw_cnt, r_drop_cnt;
    xcol_t           w_out_nxt, w_old_col, w_new_col;
    logic            w_sw_inc, w_drop_inc, w_clr_old;
    logic            w_pla_inf_nxt, w_pla_clean, w_gmii_inf_nxt, w_gmii_clean;
    logic            w_old_inf_nxt, w_new_inf_nxt, w_new_clean;
`ifdef PLA_LOOP_SEL_TIMEOUT_EN
    logic [CNT_W-1:0] r_abort_cnt;
    logic             w_abort_inc;
`endif

    pla_xgmii_frame_trk u_trk_pla (
        .i_clk         (I_sys_312m_clk),
        .i_rst         (I_fpga_reset),
        .i_col         (r_pla),
        .i_clr         (w_clr_old && !r_src),
        .o_inframe_nxt (w_pla_inf_nxt),
        .o_clean       (w_pla_clean)
    );

    pla_xgmii_frame_trk u_trk_gmii (
        .i_clk         (I_sys_312m_clk),
        .i_rst         (I_fpga_reset),
        .i_col         (r_gmii),
        .i_clr         (w_clr_old && r_src),
        .o_inframe_nxt (w_gmii_inf_nxt),
        .o_clean       (w_gmii_clean)
    );

    // "old" is the source currently owning the output, "new" the other one
    assign w_old_col     = r_src ? r_gmii : r_pla;
    assign w_new_col     = r_src ? r_pla  : r_gmii;
    assign w_old_inf_nxt = r_src ? w_gmii_inf_nxt : w_pla_inf_nxt;
    assign w_new_inf_nxt = r_src ? w_pla_inf_nxt  : w_gmii_inf_nxt;
    assign w_new_clean   = r_src ? w_pla_clean    : w_gmii_clean;

    // Request synchronizer and input column registers
    always_ff @(posedge I_sys_312m_clk or posedge I_fpga_reset) begin
        if (I_fpga_reset) begin
            r_req_meta <= 1'b0;
            r_req      <= 1'b0;
            r_pla      <= XGMII_IDLE_COL;
            r_gmii     <= XGMII_IDLE_COL;
        end else begin
            r_req_meta <= I_bypass_en;
            r_req      <= r_req_meta;
            r_pla      <= '{txc: I_pla_packing_txc, data: I_pla_packing_data};
            r_gmii     <= '{txc: I_gmii_txc, data: I_gmii_data};
        end
    end

    // Next state, output column selection and counter strobes
    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_tcnt_nxt  = r_tcnt;
        w_out_nxt   = XGMII_IDLE_COL;
        w_sw_inc    = 1'b0;
        w_drop_inc  = 1'b0;
        w_clr_old   = 1'b0;
`ifdef PLA_LOOP_SEL_TIMEOUT_EN
        w_abort_inc = 1'b0;
`endif
        case (r_state)
            ST_PLA, ST_BYP: begin
                w_out_nxt = w_old_col;
                if (r_req != r_src) begin
                    w_tcnt_nxt  = '0;
                    w_state_nxt = w_old_inf_nxt ? ST_DRAIN : ST_GAP;
                end
            end
            ST_DRAIN: begin
                w_out_nxt = w_old_col;
                if (r_req == r_src) begin
                    // Request withdrawn before the frame ended: cancel silently
                    w_state_nxt = r_src ? ST_BYP : ST_PLA;
                end else if (!w_old_inf_nxt) begin
                    w_tcnt_nxt  = '0;
                    w_state_nxt = ST_GAP;
                end
`ifdef PLA_LOOP_SEL_TIMEOUT_EN
                else if (r_tcnt == TC_W'(TIMEOUT_CYCLES - 1)) begin
                    w_out_nxt   = '{txc: XGMII_IDLE_TXC, data: XGMII_TERM_WORD};
                    w_clr_old   = 1'b1;
                    w_abort_inc = 1'b1;
                    w_tcnt_nxt  = '0;
                    w_state_nxt = ST_GAP;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
`endif
            end
            ST_GAP: begin
                w_tcnt_nxt = r_tcnt + 1'b1;
                if (r_tcnt == TC_W'(GAP_CYCLES - 1)) begin
                    w_state_nxt = ST_ALIGN;
                    // New source caught mid-frame: that frame will be skipped
                    w_drop_inc  = w_new_inf_nxt;
                end
            end
            ST_ALIGN: begin
                if (w_new_clean) begin
                    w_out_nxt   = w_new_col;
                    w_src_nxt   = !r_src;
                    w_state_nxt = r_src ? ST_PLA : ST_BYP;
                    w_sw_inc    = 1'b1;
                end
            end
            default: w_state_nxt = ST_PLA;
        endcase
    end

    // FSM, output column and status counters
    always_ff @(posedge I_sys_312m_clk or posedge I_fpga_reset) begin
        if (I_fpga_reset) begin
            r_state    <= ST_PLA;
            r_src      <= 1'b0;
            r_tcnt     <= '0;
            r_out      <= XGMII_IDLE_COL;
            r_sw_cnt   <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_src      <= w_src_nxt;
            r_tcnt     <= w_tcnt_nxt;
            r_out      <= w_out_nxt;
            r_sw_cnt   <= r_sw_cnt + CNT_W'(w_sw_inc);
            r_drop_cnt <= r_drop_cnt + CNT_W'(w_drop_inc);
        end
    end

`ifdef PLA_LOOP_SEL_TIMEOUT_EN
    // Forced-terminate counter
    always_ff @(posedge I_sys_312m_clk or posedge I_fpga_reset) begin
        if (I_fpga_reset) r_abort_cnt <= '0;
        else              r_abort_cnt <= r_abort_cnt + CNT_W'(w_abort_inc);
    end
    assign O_abort_cnt = r_abort_cnt;
`endif

    assign O_gmii_txc      = r_out.txc;
    assign O_gmii_data     = r_out.data;
    assign O_bypass_active = r_src;   // r_src flips with the new source's first column
    assign O_switch_busy   = (r_state == ST_DRAIN) || (r_state == ST_GAP) || (r_state == ST_ALIGN);
    assign O_switch_cnt    = r_sw_cnt;
    assign O_drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_pla_1588_loop_sel_ctrl.sv
// Bench for pla_1588_loop_sel_ctrl: directed column streams, a frame-level
// reference model producing expected output per column, per-cycle compare.
module tb_pla_1588_loop_sel_ctrl;

    localparam int GAP = 3;
    localparam int TO  = 16;
    localparam int N   = 100;
`ifdef PLA_LOOP_SEL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        byp = 1'b0;
    logic [3:0]  gtxc = 4'hf, ptxc = 4'hf;
    logic [31:0] gdata = 32'h07070707, pdata = 32'h07070707;
    logic [3:0]  o_txc;
    logic [31:0] o_data;
    logic        o_act, o_busy;
    logic [15:0] o_sw, o_drop;
`ifdef PLA_LOOP_SEL_TIMEOUT_EN
    logic [15:0] o_abort;
`endif

    always #5 clk = ~clk;

    pla_1588_loop_sel_ctrl #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .I_sys_312m_clk     (clk),
        .I_fpga_reset       (rst),
        .I_bypass_en        (byp),
        .I_gmii_txc         (gtxc),
        .I_gmii_data        (gdata),
        .I_pla_packing_txc  (ptxc),
        .I_pla_packing_data (pdata),
        .O_gmii_txc         (o_txc),
        .O_gmii_data        (o_data),
        .O_bypass_active    (o_act),
        .O_switch_busy      (o_busy),
        .O_switch_cnt       (o_sw),
        .O_drop_cnt         (o_drop)
`ifdef PLA_LOOP_SEL_TIMEOUT_EN
        ,
        .O_abort_cnt        (o_abort)
`endif
    );

    // stimulus per column and expected results per column
    logic [3:0]  s_ptxc[N], s_gtxc[N];
    logic [31:0] s_pdata[N], s_gdata[N];
    logic        s_byp[N];
    logic [3:0]  e_txc[N];
    logic [31:0] e_data[N];
    bit          e_act[N], e_busy[N];
    int          e_sw[N], e_drop[N], e_ab[N];

    int errors = 0, checks = 0;
    int cyc = -1, n_run = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic clear_stim();
        for (int k = 0; k < N; k++) begin
            s_ptxc[k] = 4'hf; s_pdata[k] = 32'h07070707;
            s_gtxc[k] = 4'hf; s_gdata[k] = 32'h07070707;
            s_byp[k]  = 1'b0;
        end
    endtask

    // Frame: SOF column, payload columns, EOF with terminate in lane 1
    task automatic put_frame(input bit g, input int st, input int len, input bit term);
        for (int j = 0; j < len; j++) begin
            logic [3:0] t; logic [31:0] d;
            if (j == 0) begin
                t = 4'b0001; d = {8'h55, 8'h55, 8'h55, 8'hFB};
            end else if (j == len - 1 && term) begin
                t = 4'b1110; d = {8'h07, 8'h07, 8'hFD, 8'(j)};
            end else begin
                t = 4'b0000; d = {8'(st + j), 8'(j), (g ? 8'hA5 : 8'h5A), 8'(j * 3 + 1)};
            end
            if (g) begin s_gtxc[st + j] = t; s_gdata[st + j] = d; end
            else   begin s_ptxc[st + j] = t; s_pdata[st + j] = d; end
        end
    endtask

    task automatic set_byp(input int from, input int to);
        for (int k = from; k < to && k < N; k++) s_byp[k] = 1'b1;
    endtask

    // Reference model: walk the columns, tracking which source owns the
    // link, whether it is finishing a frame, idles still owed, and whether
    // we are waiting for the other source to be between frames.
    task automatic run_model();
        int own = 0, gap_left = 0, dcnt = 0, sw = 0, drop = 0, ab = 0;
        bit hunting = 0, draining = 0;
        bit inf[2] = '{1'b0, 1'b0};
        for (int k = 0; k < N; k++) begin
            bit req; logic [35:0] c[2]; logic [35:0] o;
            bit sof[2], eof[2], nxt[2];
            req  = (k == 0) ? 1'b0 : s_byp[k-1];
            c[0] = {s_ptxc[k], s_pdata[k]};
            c[1] = {s_gtxc[k], s_gdata[k]};
            for (int s = 0; s < 2; s++) begin
                sof[s] = c[s][32] && (c[s][7:0] == 8'hFB);
                eof[s] = 1'b0;
                for (int b = 0; b < 4; b++)
                    if (c[s][32+b] && (c[s][8*b +: 8] == 8'hFD)) eof[s] = 1'b1;
                nxt[s] = sof[s] ? 1'b1 : (eof[s] ? 1'b0 : inf[s]);
            end
            o = {4'hf, 32'h07070707};
            if (gap_left > 0) begin
                gap_left--;
                if (gap_left == 0) begin
                    hunting = 1;
                    if (nxt[1-own]) drop++;
                end
            end else if (hunting) begin
                if (!inf[1-own]) begin
                    o = c[1-own]; own = 1 - own; hunting = 0; sw++;
                end
            end else if (draining) begin
                o = c[own];
                dcnt++;
                if (req == own[0]) draining = 0;
                else if (!nxt[own]) begin draining = 0; gap_left = GAP; end
                else if (TO_EN && dcnt == TO) begin
                    o = {4'hf, 32'h070707FD}; nxt[own] = 1'b0;
                    draining = 0; gap_left = GAP; ab++;
                end
            end else begin
                o = c[own];
                if (req != own[0]) begin
                    if (nxt[own]) begin draining = 1; dcnt = 0; end
                    else gap_left = GAP;
                end
            end
            inf = nxt;
            e_txc[k]  = o[35:32];
            e_data[k] = o[31:0];
            e_act[k]  = (own == 1);
            e_busy[k] = draining || hunting || (gap_left > 0);
            e_sw[k] = sw; e_drop[k] = drop; e_ab[k] = ab;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; byp = 1'b0;
        ptxc = 4'hf; pdata = 32'h07070707; gtxc = 4'hf; gdata = 32'h07070707;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_seg(input int n);
        for (int e = 0; e < n; e++) begin
            @(negedge clk);
            if (e == 0) begin cyc = -1; n_run = n; chk_en = 1'b1; end
            ptxc = s_ptxc[e]; pdata = s_pdata[e];
            gtxc = s_gtxc[e]; gdata = s_gdata[e];
            byp  = s_byp[e];
        end
        @(negedge clk);
        chk_en = 1'b0;
    endtask

    // Compare process: output after edge e belongs to column e-1
    always @(posedge clk) begin
        int k;
        if (chk_en) begin
            cyc = cyc + 1;
            #1;
            if (cyc >= 1 && cyc <= n_run - 1) begin
                k = cyc - 1;
                chk("txc",  o_txc,  e_txc[k]);
                chk("data", o_data, e_data[k]);
                chk("bypass_active", o_act, e_act[k]);
                chk("switch_busy",   o_busy, e_busy[k]);
                chk("switch_cnt", o_sw,   16'(e_sw[k]));
                chk("drop_cnt",   o_drop, 16'(e_drop[k]));
`ifdef PLA_LOOP_SEL_TIMEOUT_EN
                chk("abort_cnt",  o_abort, 16'(e_ab[k]));
`endif
            end
        end
    end

    task automatic setup_t1();
        clear_stim();
        put_frame(1'b0, 2, 10, 1'b1);
        put_frame(1'b1, 3, 8, 1'b1);
        run_model();
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, "_txc"},  o_txc,  4'hf);
        chk({nm, "_data"}, o_data, 32'h07070707);
        chk({nm, "_busy"}, o_busy, 1'b0);
        chk({nm, "_act"},  o_act,  1'b0);
        chk({nm, "_sw"},   o_sw,   16'd0);
        chk({nm, "_drop"}, o_drop, 16'd0);
    endtask

    initial begin
        bit same;
        // T1: PLA passthrough
        setup_t1();
        chk("t1_pin_sof", e_data[2], {8'h55, 8'h55, 8'h55, 8'hFB});
        do_reset();
        check_reset_state("reset");
        run_seg(40);
        chk("t1_sw_final", o_sw, 16'd0);

        // T2: switch to GMII after PLA frame, GMII idle
        clear_stim();
        put_frame(1'b0, 2, 10, 1'b1);
        put_frame(1'b1, 30, 6, 1'b1);
        set_byp(4, N);
        run_model();
        chk("t2_pin_eof",  {e_txc[11], e_data[11]}, {4'he, 8'h07, 8'h07, 8'hFD, 8'd9});
        chk("t2_pin_gap",  {e_data[12], e_data[13], e_data[14]}, {3{32'h07070707}});
        chk("t2_pin_own",  {e_act[14], e_act[15]}, 2'b01);
        do_reset();
        run_seg(50);
        chk("t2_sw_final",  o_sw,  16'd1);
        chk("t2_act_final", o_act, 1'b1);

        // T3: GMII mid-frame when the gap ends
        clear_stim();
        put_frame(1'b0, 2, 10, 1'b1);
        put_frame(1'b1, 11, 12, 1'b1);
        put_frame(1'b1, 26, 5, 1'b1);
        set_byp(4, N);
        run_model();
        chk("t3_pin_hold", {e_data[22], e_act[22], e_act[23]}, {32'h07070707, 2'b01});
        chk("t3_pin_sof",  e_data[26], {8'h55, 8'h55, 8'h55, 8'hFB});
        do_reset();
        run_seg(50);
        chk("t3_drop_final", o_drop, 16'd1);
        chk("t3_sw_final",   o_sw,   16'd1);

        // T4: short request pulse mid-frame is withdrawn
        clear_stim();
        put_frame(1'b0, 2, 40, 1'b1);
        set_byp(10, 14);
        run_model();
        same = 1'b1;
        for (int k = 0; k < N; k++)
            if (e_data[k] !== s_pdata[k] || e_txc[k] !== s_ptxc[k]) same = 1'b0;
        chk("t4_pin_nogap", same, 1'b1);
        chk("t4_pin_busy",  {e_busy[10], e_busy[11], e_busy[14], e_busy[15]}, 4'b0110);
        do_reset();
        run_seg(60);
        chk("t4_sw_final", o_sw, 16'd0);

        // T5: reset while draining
        clear_stim();
        put_frame(1'b0, 2, 40, 1'b1);
        set_byp(4, N);
        run_model();
        do_reset();
        run_seg(16);
        chk("t5_busy_pre", o_busy, 1'b1);
        chk("t5_data_pre", o_data, s_pdata[14]);
        #1 rst = 1'b1;
        #1 check_reset_state("t5_async");
        setup_t1();
        do_reset();
        run_seg(40);
        chk("t5_resume_sw", o_sw, 16'd0);

`ifdef PLA_LOOP_SEL_TIMEOUT_EN
        // T6: unterminated PLA frame hits the drain watchdog
        clear_stim();
        put_frame(1'b0, 2, 70, 1'b0);
        set_byp(4, N);
        run_model();
        chk("t6_pin_term", {e_txc[21], e_data[21]}, {4'hf, 32'h070707FD});
        chk("t6_pin_own",  {e_act[24], e_act[25]}, 2'b01);
        do_reset();
        run_seg(50);
        chk("t6_abort_final", o_abort, 16'd1);
        chk("t6_sw_final",    o_sw,    16'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
